// File: rtl/enigma_pkg.sv
// Shared types and constants for the rotor-position front end.
// FSM encodings, letter range and load-select encodings.
package enigma_pkg;

  localparam int LETTER_W = 5;
  localparam logic [LETTER_W-1:0] LETTER_MAX = 5'd25;

  localparam logic [1:0] SEL_CLR = 2'd0;
  localparam logic [1:0] SEL_R1  = 2'd1;
  localparam logic [1:0] SEL_R2  = 2'd2;
  localparam logic [1:0] SEL_R3  = 2'd3;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_STEP_OUT     = 3'd1;
  localparam logic [2:0] ST_SETTLE       = 3'd2;
  localparam logic [2:0] ST_ISSUE        = 3'd3;
  localparam logic [2:0] ST_LOAD_OUT     = 3'd4;
  localparam logic [2:0] ST_WAIT_RELEASE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE         = ST_IDLE,
    S_STEP_OUT     = ST_STEP_OUT,
    S_SETTLE       = ST_SETTLE,
    S_ISSUE        = ST_ISSUE,
    S_LOAD_OUT     = ST_LOAD_OUT,
    S_WAIT_RELEASE = ST_WAIT_RELEASE
  } key_state_t;

  function automatic logic is_letter(input logic [LETTER_W-1:0] code);
    return (code <= LETTER_MAX);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus consecutive-cycle debouncer with a rising-edge pulse.
// The edge pulse is suppressed until the input has been seen low once after reset.
module key_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = (CYCLES < 1) ? '0 : CW'(CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;
  logic [1:0]    r_flush;
  logic          r_armed;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_flush <= 2'd0;
      r_armed <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        // Terminal compare stops the count before it can ever wrap.
        if (r_cnt >= C_LAST) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      // Wait for the synchroniser to hold real samples before trusting a "released" level.
      if (r_flush != 2'd2) begin
        r_flush <= r_flush + 2'd1;
      end else if (!r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise & r_armed;

endmodule

// File: rtl/key_step_ctrl.sv
// Letter-key / load-button front end: debounces inputs, issues STEP, settles,
// then presents the letter; setup-mode presses and the load button drive LD/SEL/RNOTCH.
module key_step_ctrl
  import enigma_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_key_valid,
  input  logic [LETTER_W-1:0] i_key_code,
  input  logic                i_mode,
  input  logic [1:0]          i_set_sel,
  input  logic                i_ld_btn,
  output logic                o_step,
  output logic                o_ld,
  output logic [1:0]          o_sel,
  output logic [LETTER_W-1:0] o_rnotch,
  output logic [LETTER_W-1:0] o_letter,
  output logic                o_letter_valid,
  output logic                o_busy,
  output logic                o_err
);

  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES < 1) ? '0 : SW'(SETTLE_CYCLES - 1);

  logic w_key_level;
  logic w_key_rise;
  logic w_ld_level;
  logic w_ld_rise;

  key_state_t          r_state;
  logic [SW-1:0]       r_settle_cnt;
  logic                r_step;
  logic                r_ld;
  logic [1:0]          r_sel;
  logic [LETTER_W-1:0] r_rnotch;
  logic [LETTER_W-1:0] r_letter;
  logic                r_letter_valid;
  logic                r_err;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_raw   (i_key_valid),
    .o_level (w_key_level),
    .o_rise  (w_key_rise)
  );

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ld_db (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_raw   (i_ld_btn),
    .o_level (w_ld_level),
    .o_rise  (w_ld_rise)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_WAIT_RELEASE;
      r_settle_cnt   <= '0;
      r_step         <= 1'b0;
      r_ld           <= 1'b0;
      r_sel          <= SEL_CLR;
      r_rnotch       <= '0;
      r_letter       <= '0;
      r_letter_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_step         <= 1'b0;
      r_ld           <= 1'b0;
      r_letter_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A key edge takes priority; a coincident load edge is dropped.
          if (w_key_rise) begin
            if (!is_letter(i_key_code)) begin
              r_err   <= 1'b1;
              r_state <= S_WAIT_RELEASE;
            end else if (!i_mode) begin
              r_letter <= i_key_code;
              r_err    <= 1'b0;
              r_step   <= 1'b1;
              r_state  <= S_STEP_OUT;
            end else begin
              r_rnotch <= i_key_code;
              r_err    <= 1'b0;
              r_state  <= S_WAIT_RELEASE;
            end
          end else if (w_ld_rise) begin
            r_sel   <= i_set_sel;
            r_ld    <= 1'b1;
            r_state <= S_LOAD_OUT;
          end
        end
        S_STEP_OUT: begin
          r_settle_cnt <= '0;
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_settle_cnt >= SETTLE_LAST) begin
            r_letter_valid <= 1'b1;
            r_state        <= S_ISSUE;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_RELEASE;
        end
        S_LOAD_OUT: begin
          r_state <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!w_key_level && !w_ld_level) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_WAIT_RELEASE;
        end
      endcase
    end
  end

  assign o_step         = r_step;
  assign o_ld           = r_ld;
  assign o_sel          = r_sel;
  assign o_rnotch       = r_rnotch;
  assign o_letter       = r_letter;
  assign o_letter_valid = r_letter_valid;
  assign o_err          = r_err;
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_key_step_ctrl.sv
// Scoreboard bench: stimulus pushes expected STEP/LD/LETTER_VALID events,
// a monitor pops and compares them whenever the DUT pulses an output.
module tb_key_step_ctrl;

  localparam int DB = 4;
  localparam int ST = 2;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [4:0] key_code = 5'd0;
  logic       mode = 1'b0;
  logic [1:0] set_sel = 2'd0;
  logic       ld_btn = 1'b0;
  logic       step, ld, letter_valid, busy, err;
  logic [1:0] sel;
  logic [4:0] rnotch, letter;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int kind;
    int at;
    int data;
  } ev_t;

  ev_t exp_q[$];

  key_step_ctrl #(.DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_key_valid    (key_valid),
    .i_key_code     (key_code),
    .i_mode         (mode),
    .i_set_sel      (set_sel),
    .i_ld_btn       (ld_btn),
    .o_step         (step),
    .o_ld           (ld),
    .o_sel          (sel),
    .o_rnotch       (rnotch),
    .o_letter       (letter),
    .o_letter_valid (letter_valid),
    .o_busy         (busy),
    .o_err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp_v, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int data);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind, input int data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event kind=%0d actual_cycle=%0d expected=none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.at);
      chk("event_data", data, e.data);
    end
  endtask

  // kind 0 = STEP, 1 = LD (data {sel,rnotch}), 2 = LETTER_VALID (data letter)
  always @(negedge clk) begin
    if (step === 1'b1)         see(0, 0);
    if (ld === 1'b1)           see(1, {25'd0, sel, rnotch});
    if (letter_valid === 1'b1) see(2, {27'd0, letter});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [6:0] pat;
    logic bad;

    // Async reset asserted mid-cycle before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_step", step, 0);
    chk("rst_ld", ld, 0);
    chk("rst_lv", letter_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_sel", sel, 0);
    chk("rst_rnotch", rnotch, 0);
    chk("rst_letter", letter, 0);
    chk("rst_busy", busy, 1);
    tick(3);
    rst = 1'b0;
    chk("busy_at_release", busy, 1);
    tick(1);
    chk("busy_after_release", busy, 0);
    tick(5);

    // Clean press, code changes after acceptance are ignored
    key_code = 5'd7; mode = 1'b0;
    n = cyc; key_valid = 1'b1;
    push(0, n + LAT, 0);
    push(2, n + LAT + ST + 1, 7);
    tick(8);
    key_code = 5'd9;
    chk("busy_in_settle", busy, 1);
    tick(42);
    key_valid = 1'b0;
    tick(15);
    chk("idle_after_press", busy, 0);

    // Bounce: never DB consecutive stable samples
    pat = 7'b1110111;
    bad = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      key_valid = pat[i];
      tick(1);
      if (busy !== 1'b0) bad = 1'b1;
    end
    key_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy !== 1'b0) bad = 1'b1;
    end
    chk("bounce_busy_stuck_low", {31'd0, bad}, 0);

    // Setup press captures RNOTCH, no STEP
    mode = 1'b1; key_code = 5'd12;
    key_valid = 1'b1;
    tick(8);
    key_code = 5'd20;
    tick(2);
    key_valid = 1'b0;
    tick(12);
    chk("setup_rnotch", rnotch, 12);
    chk("setup_idle", busy, 0);

    // Load button with SET_SEL = 2
    set_sel = 2'd2;
    n = cyc; ld_btn = 1'b1;
    push(1, n + LAT, (2 << 5) | 12);
    tick(9);
    set_sel = 2'd3;
    tick(1);
    ld_btn = 1'b0;
    tick(12);
    chk("load_sel_held", sel, 2);

    // Illegal code sets ERR, no STEP
    mode = 1'b0; key_code = 5'd27;
    key_valid = 1'b1;
    tick(10);
    key_valid = 1'b0;
    tick(12);
    chk("illegal_err", err, 1);
    chk("illegal_rnotch_hold", rnotch, 12);

    // Legal code clears ERR
    key_code = 5'd3;
    n = cyc; key_valid = 1'b1;
    push(0, n + LAT, 0);
    push(2, n + LAT + ST + 1, 3);
    tick(LAT + 1);
    chk("err_cleared", err, 0);
    tick(2);
    key_valid = 1'b0;
    tick(14);
    chk("letter_3", letter, 3);

    // Key and load edges together: key wins
    key_code = 5'd11; set_sel = 2'd1;
    n = cyc; key_valid = 1'b1; ld_btn = 1'b1;
    push(0, n + LAT, 0);
    push(2, n + LAT + ST + 1, 11);
    tick(10);
    key_valid = 1'b0; ld_btn = 1'b0;
    tick(14);
    chk("coincident_sel_unchanged", sel, 2);

    // Reset during SETTLE with key held
    key_code = 5'd5;
    n = cyc; key_valid = 1'b1;
    push(0, n + LAT, 0);
    tick(LAT + 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_lv", letter_valid, 0);
    chk("midrst_letter", letter, 0);
    chk("midrst_busy", busy, 1);
    tick(2);
    rst = 1'b0;
    tick(20);
    chk("held_after_reset_idle", busy, 0);
    key_valid = 1'b0;
    tick(15);

    // Fresh press after release is accepted
    key_code = 5'd6;
    n = cyc; key_valid = 1'b1;
    push(0, n + LAT, 0);
    push(2, n + LAT + ST + 1, 6);
    tick(12);
    key_valid = 1'b0;
    tick(14);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_step_ctrl.md
# key_step_ctrl

- Front-end controller for the rotor-position stage.
- Converts raw letter-key and load-button inputs into clean control for the rotor-position counters:
  - debounced single-cycle STEP pulses;
  - LD/SEL/RNOTCH load commands.
- Presents the accepted letter to the cipher path only after the rotors have stepped and settled.
- Sits between the board buttons/switches and the rotor-position block.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
- SETTLE_CYCLES, 2: cycles between STEP and LETTER_VALID, so rotor positions propagate.

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- KEY_VALID  in  1  raw, asynchronous letter-key-down level.
- KEY_CODE  in  5  letter code; legal range 0–25.
- MODE  in  1  0 = encrypt, 1 = setup.
- SET_SEL  in  2  load target: 0 = clear all, 1–3 = rotor 1–3.
- LD_BTN  in  1  raw, asynchronous load button.
- STEP  out  1  one-cycle registered pulse that advances rotor 1.
- LD  out  1  one-cycle registered load pulse.
- SEL  out  2  registered load select; stable while LD is high.
- RNOTCH  out  5  registered load value.
- LETTER  out  5  accepted letter.
- LETTER_VALID  out  1  one-cycle strobe qualifying LETTER.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky illegal-code flag.

## Operation
Input conditioning:
- KEY_VALID and LD_BTN each pass through a 2-flop synchroniser, then a debouncer.
- The debouncer's clean output changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any mismatch gap restarts the count.

FSM states: IDLE, STEP_OUT, SETTLE, ISSUE, LOAD_OUT, WAIT_RELEASE.

IDLE:
- Clean key rising edge with MODE = 0 and KEY_CODE ≤ 25:
  - capture KEY_CODE into LETTER;
  - clear ERR;
  - go to STEP_OUT.
- Clean key rising edge with MODE = 1 and KEY_CODE ≤ 25:
  - capture KEY_CODE into RNOTCH;
  - clear ERR;
  - go to WAIT_RELEASE.
- Clean key rising edge with KEY_CODE > 25 (either mode):
  - set ERR;
  - no STEP;
  - go to WAIT_RELEASE.
- Clean LD_BTN rising edge:
  - latch SET_SEL into SEL;
  - go to LOAD_OUT.
- Key and LD_BTN edges in the same cycle: the key wins; the LD edge is dropped.
- LD_BTN is honoured in either MODE.

STEP_OUT:
- STEP = 1 for exactly one cycle; go to SETTLE.

SETTLE:
- Count SETTLE_CYCLES cycles, then go to ISSUE.

ISSUE:
- LETTER_VALID = 1 for one cycle; go to WAIT_RELEASE.

LOAD_OUT:
- LD = 1 for one cycle, with SEL and RNOTCH stable; go to WAIT_RELEASE.

WAIT_RELEASE:
- Remain until both clean inputs are low, then go to IDLE.
- Holding a key never auto-repeats.

General rules:
- MODE, KEY_CODE and SET_SEL are sampled only on the accepting IDLE cycle. Changes during any other state are ignored.
- LETTER and RNOTCH hold their values until the next capture.

## Timing
- Reset values:
  - STEP, LD, LETTER_VALID, ERR = 0;
  - SEL = 0, RNOTCH = 0, LETTER = 0;
  - BUSY = 1;
  - debouncer outputs and synchronisers = 0;
  - FSM = WAIT_RELEASE.
- Exit from reset: with keys low, the FSM reaches IDLE one cycle after reset releases. A key held through reset must be released before a new press is accepted.
- Reset mid-operation aborts immediately; no pending STEP, LD or LETTER_VALID is issued afterwards.
- Press latency: raw KEY_VALID rise at cycle 0 → STEP high at cycle DEBOUNCE_CYCLES + 3.
- STEP → LETTER_VALID: SETTLE_CYCLES + 1 cycles. With the default (2) this is 3 cycles.
- Load latency: raw LD_BTN rise at cycle 0 → LD high at cycle DEBOUNCE_CYCLES + 3.
- Debounce counter: width is ceil(log2(DEBOUNCE_CYCLES + 1)); it saturates and never wraps.
- Minimum spacing between accepted presses: release debounce + press debounce.

## Structure
Shared package enigma_pkg holds:
- state enum key_state_t;
- LETTER_MAX = 25;
- LETTER_W = 5;
- SEL encodings SEL_CLR = 0 and SEL_R1..SEL_R3 = 1..3.

Sub-module key_debounce (parameter CYCLES):
- contains the 2-flop synchroniser, counter and clean-level register;
- outputs a clean level plus a one-cycle rising-edge pulse;
- instantiated twice, once for KEY_VALID and once for LD_BTN.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and SETTLE_CYCLES = 2.
- Reset: assert RST asynchronously mid-cycle → all outputs at their reset values immediately; with keys low, BUSY = 0 one cycle after release.
- Clean press: KEY_CODE = 7, MODE = 0, held 50 cycles → exactly one STEP at cycle 7, LETTER = 7 with LETTER_VALID at cycle 10, no repeat.
- Bounce: KEY_VALID high 3, low 1, high 3, then low → no STEP, no LETTER_VALID, BUSY stays 0.
- Setup: MODE = 1, KEY_CODE = 12 press/release, then LD_BTN with SET_SEL = 2 → RNOTCH = 12, SEL = 2, LD one cycle, STEP never asserted.
- Illegal code: KEY_CODE = 27 → ERR = 1, no STEP; next press with KEY_CODE = 3 → ERR = 0, STEP once, LETTER = 3.
- Reset during SETTLE with the key still held → LETTER_VALID never fires; after release, no STEP until the key is released and pressed again.
